// File: rtl/regfile_pkg.sv
// regfile_pkg: shared width/depth constants, bus types and logic levels for regfile
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int DATA_D = 32;
  localparam int ADDR_W = 5;
  typedef logic [DATA_W-1:0] data_bus_t;
  typedef logic [ADDR_W-1:0] addr_bus_t;
  localparam logic HIGH = 1'b1;
  localparam logic LOW = 1'b0;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
endpackage

// File: rtl/regfile.sv
// regfile: single-port register file, synchronous write, combinational read
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int DATA_D = regfile_pkg::DATA_D,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              we_,
  output logic [DATA_W-1:0] d_out
);
  logic [DATA_W-1:0] ff [DATA_D];
  // clear all entries on reset, otherwise write the addressed entry when enabled
  always_ff @(posedge clk)
    for (int k = 0; k < DATA_D; k++)
      if (reset == HIGH) ff[k] <= '0;
      else if (we_ == ENABLE_ && addr == ADDR_W'(k)) ff[k] <= d_in;
  // out-of-range addresses read as zero
  always_comb d_out = (int'(addr) < DATA_D) ? ff[addr] : '0;
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: randomized and directed checks of regfile against an array model
module tb_regfile;
  logic clk = 0;
  logic reset = 1;
  logic [4:0] addr = '0;
  logic [31:0] d_in = '0;
  logic we_ = 1;
  logic [31:0] d_out;
  logic [31:0] model [32];
  bit mvalid = 0;
  int checks = 0;
  int errors = 0;

  regfile dut (.clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .we_(we_), .d_out(d_out));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mvalid) begin
      checks++;
      if (d_out !== model[addr]) begin
        errors++;
        $display("FAIL cmp t=%0t addr=%0d got=%h exp=%h", $time, addr, d_out, model[addr]);
      end
    end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
    reset = r; we_ = w; addr = a; d_in = d;
    @(posedge clk);
    if (r) begin
      foreach (model[k]) model[k] = '0;
      mvalid = 1;
    end else if (!w) model[a] = d;
    #1;
  endtask

  task automatic peek(input string name, input logic [4:0] a, input logic [31:0] exp);
    reset = 0; we_ = 1; addr = a;
    #1;
    check(name, d_out, exp);
  endtask

  initial begin
    drive(1, 1, 0, 0);
    for (int k = 0; k < 32; k++) peek("reset_zero", 5'(k), 0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 5'(i), 32'(i));
      check("write_readback", d_out, 32'(i));
    end
    for (int k = 0; k < 32; k++) peek("sweep", 5'(k), 32'(k));
    repeat (4) drive(0, 1, 5, 32'hDEADBEEF);
    check("write_disabled", d_out, 32'd5);
    drive(0, 0, 7, 32'hA5A5A5A5);
    drive(0, 0, 7, 32'h5A5A5A5A);
    peek("overwrite7", 7, 32'h5A5A5A5A);
    peek("isolate6", 6, 32'd6);
    peek("isolate8", 8, 32'd8);
    reset = 0; we_ = 0; addr = 3; d_in = 32'h1234;
    #1;
    check("no_bypass_before", d_out, 32'd3);
    @(posedge clk);
    model[3] = 32'h1234;
    #1;
    check("no_bypass_after", d_out, 32'h1234);
    for (int n = 0; n < 2000; n++)
      drive($urandom_range(63) == 0, 1'($urandom), 5'($urandom), $urandom);
    for (int k = 0; k < 32; k++) drive(0, 0, 5'(k), $urandom | 32'h1);
    peek("loaded_nonzero", 2, model[2]);
    drive(1, 0, 2, 32'hFFFF);
    for (int k = 0; k < 32; k++) peek("reset_mid", 5'(k), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
